// File: rtl/booth_mult_vr.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on operand and product sides.
// Optional BOOTH_MULT_B2B_EN: accept the next operands in DONE for zero-bubble back-to-back operation.
module booth_mult_vr #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 is_signed,
   output logic                 dest_valid,
   input  logic                 dest_ready,
   output logic [2*WIDTH-1:0]   product
);

   // state  | meaning
   // S_IDLE | waiting for operands, src_ready=1
   // S_RUN  | one Booth step per cycle, WIDTH+1 steps
   // S_DONE | product presented, waiting for dest_ready

   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH:0]       q_q, q_d;
   logic                 q1_q, q1_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       a_n;
   logic [WIDTH:0]       q_n;
   logic                 load;

   always_comb begin
      sum = a_q;
      case ({q_q[0], q1_q})
         2'b10:   sum = a_q - m_q;
         2'b01:   sum = a_q + m_q;
         default: sum = a_q;
      endcase
      a_n = {sum[WIDTH], sum[WIDTH:1]};
      q_n = {sum[0], q_q[WIDTH:1]};
   end

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      a_d        = a_q;
      q_d        = q_q;
      q1_d       = q1_q;
      count_d    = count_q;
      product_d  = product_q;
      src_ready  = 1'b0;
      dest_valid = 1'b0;
      load       = 1'b0;

      case (state_q)
         S_IDLE: begin
            src_ready = 1'b1;
            if (src_valid) load = 1'b1;
         end
         S_RUN: begin
            a_d     = a_n;
            q_d     = q_n;
            q1_d    = q_q[0];
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               // {A,Q} is 2*WIDTH+2 bits; the top two are sign copies and dropped.
               product_d = {a_n[WIDTH-2:0], q_n};
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            dest_valid = 1'b1;
`ifdef BOOTH_MULT_B2B_EN
            src_ready = dest_ready;
            if (dest_ready) begin
               if (src_valid) load = 1'b1;
               else           state_d = S_IDLE;
            end
`else
            if (dest_ready) state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         m_d     = {multiplicand[WIDTH-1] & is_signed, multiplicand};
         q_d     = {multiplier[WIDTH-1] & is_signed, multiplier};
         a_d     = '0;
         q1_d    = 1'b0;
         count_d = CW'(WIDTH + 1);
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         a_q       <= a_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_booth_mult_vr.sv
// Directed-vector bench for booth_mult_vr (WIDTH=16); adapts expected spacing to BOOTH_MULT_B2B_EN.
module tb_booth_mult_vr;

   localparam int W = 16;

`ifdef BOOTH_MULT_B2B_EN
   localparam int B2B_SPACING = 18;
`else
   localparam int B2B_SPACING = 19;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           src_valid = 1'b0;
   logic           src_ready;
   logic [W-1:0]   multiplicand = '0;
   logic [W-1:0]   multiplier = '0;
   logic           is_signed = 1'b0;
   logic           dest_valid;
   logic           dest_ready = 1'b0;
   logic [2*W-1:0] product;

   int n_cmp = 0;
   int n_err = 0;

   booth_mult_vr #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .src_valid(src_valid), .src_ready(src_ready),
      .multiplicand(multiplicand), .multiplier(multiplier), .is_signed(is_signed),
      .dest_valid(dest_valid), .dest_ready(dest_ready), .product(product)
   );

   always #5 clk = ~clk;

   // Launch one operation, wait for its result, accept it. lat = posedges from handshake to dest_valid.
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s,
                         output logic [2*W-1:0] p, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!src_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      multiplicand = m;
      multiplier   = q;
      is_signed    = s;
      src_valid    = 1'b1;
      dest_ready   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      src_valid = 1'b0;
      lat = 0;
      while (!dest_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      p = product;
      dest_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dest_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (src_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_src_ready got %b want 1", src_ready);
      end
      n_cmp++;
      if (dest_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_dest_valid got %b want 0", dest_valid);
      end
      n_cmp++;
      if (product !== 32'h0) begin
         n_err++; $display("FAIL reset_product got %h want 00000000", product);
      end
   endtask

   task automatic test_signed();
      logic [2*W-1:0] p;
      int lat;
      run_op(16'hFFF9, 16'h0003, 1'b1, p, lat);
      n_cmp++;
      if (p !== 32'hFFFF_FFEB) begin
         n_err++; $display("FAIL signed_m7x3 got %h want ffffffeb", p);
      end
      n_cmp++;
      if (lat !== 17) begin
         n_err++; $display("FAIL signed_latency got %0d want 17", lat);
      end
      run_op(16'h8000, 16'h8000, 1'b1, p, lat);
      n_cmp++;
      if (p !== 32'h4000_0000) begin
         n_err++; $display("FAIL signed_min_sq got %h want 40000000", p);
      end
      run_op(16'h0005, 16'hFFFF, 1'b1, p, lat);
      n_cmp++;
      if (p !== 32'hFFFF_FFFB) begin
         n_err++; $display("FAIL signed_5xm1 got %h want fffffffb", p);
      end
   endtask

   task automatic test_unsigned();
      logic [2*W-1:0] p;
      int lat;
      run_op(16'hFFFF, 16'hFFFF, 1'b0, p, lat);
      n_cmp++;
      if (p !== 32'hFFFE_0001) begin
         n_err++; $display("FAIL unsigned_max_sq got %h want fffe0001", p);
      end
      n_cmp++;
      if (lat !== 17) begin
         n_err++; $display("FAIL unsigned_latency got %0d want 17", lat);
      end
      run_op(16'h0000, 16'h1234, 1'b0, p, lat);
      n_cmp++;
      if (p !== 32'h0) begin
         n_err++; $display("FAIL unsigned_zero got %h want 00000000", p);
      end
      run_op(16'h0005, 16'hFFFF, 1'b0, p, lat);
      n_cmp++;
      if (p !== 32'h0004_FFFB) begin
         n_err++; $display("FAIL unsigned_5xffff got %h want 0004fffb", p);
      end
   endtask

   task automatic test_backpressure();
      int guard;
      int bad;
      @(negedge clk);
      multiplicand = 16'd3;
      multiplier   = 16'd4;
      is_signed    = 1'b1;
      src_valid    = 1'b1;
      dest_ready   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      multiplicand = 16'd9;
      multiplier   = 16'd9;
      guard = 0;
      while (!dest_valid && guard < 100) begin
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (guard !== 17) begin
         n_err++; $display("FAIL bp_latency got %0d want 17", guard);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (dest_valid !== 1'b1 || product !== 32'd12 || src_ready !== 1'b0) bad++;
         @(posedge clk);
         @(negedge clk);
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++; $display("FAIL bp_hold got %0d bad cycles want 0 (dv=%b prod=%h rdy=%b)",
                           bad, dest_valid, product, src_ready);
      end
      src_valid  = 1'b0;
      dest_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dest_ready = 1'b0;
      n_cmp++;
      if (dest_valid !== 1'b0 || src_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release got dv=%b rdy=%b want dv=0 rdy=1", dest_valid, src_ready);
      end
      n_cmp++;
      if (product !== 32'd12) begin
         n_err++; $display("FAIL bp_product_after got %h want 0000000c", product);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [2*W-1:0] p;
      int lat;
      int seen;
      @(negedge clk);
      multiplicand = 16'd100;
      multiplier   = 16'd200;
      is_signed    = 1'b0;
      src_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      src_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if (dest_valid !== 1'b0 || product !== 32'h0 || src_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_run got dv=%b prod=%h rdy=%b want 0 00000000 1",
                           dest_valid, product, src_ready);
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dest_valid) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_err++; $display("FAIL rst_abort_silent got %0d valid cycles want 0", seen);
      end
      run_op(16'd3, 16'd4, 1'b0, p, lat);
      n_cmp++;
      if (p !== 32'd12 || lat !== 17) begin
         n_err++; $display("FAIL rst_then_3x4 got %h lat %0d want 0000000c lat 17", p, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   ms [4];
      logic [W-1:0]   qs [4];
      logic           ss [4];
      logic [2*W-1:0] exp_p [4];
      int t [4];
      int issued, got, cyc;
      logic hs;
      ms[0] = 16'hFFFD; qs[0] = 16'd5;    ss[0] = 1'b1; exp_p[0] = 32'hFFFF_FFF1;
      ms[1] = 16'd123;  qs[1] = 16'hFFFE; ss[1] = 1'b1; exp_p[1] = 32'hFFFF_FF0A;
      ms[2] = 16'd1000; qs[2] = 16'd1000; ss[2] = 1'b0; exp_p[2] = 32'h000F_4240;
      ms[3] = 16'h8000; qs[3] = 16'd2;    ss[3] = 1'b0; exp_p[3] = 32'h0001_0000;
      issued = 0; got = 0; cyc = 0;
      dest_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         @(negedge clk);
         if (issued < 4) begin
            multiplicand = ms[issued];
            multiplier   = qs[issued];
            is_signed    = ss[issued];
            src_valid    = 1'b1;
         end else begin
            src_valid = 1'b0;
         end
         if (dest_valid) begin
            n_cmp++;
            if (product !== exp_p[got]) begin
               n_err++; $display("FAIL b2b_product%0d got %h want %h", got, product, exp_p[got]);
            end
            t[got] = cyc;
            got++;
         end
         hs = src_valid && src_ready;
         @(posedge clk);
         cyc++;
         if (hs) issued++;
      end
      @(negedge clk);
      src_valid  = 1'b0;
      dest_ready = 1'b0;
      n_cmp++;
      if (got !== 4) begin
         n_err++; $display("FAIL b2b_timeout got %0d results want 4", got);
      end else begin
         for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (t[i] - t[i-1] !== B2B_SPACING) begin
               n_err++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, t[i] - t[i-1], B2B_SPACING);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_signed();
      test_unsigned();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
